// File: rtl/vec_mag_rr_arbiter.sv
// Round-robin front end sharing one vec_mag_top stream pipeline between N_REQ requesters.
// Define VEC_ARB_PKT_LOCK_EN to hold the grant for a whole packet (until tlast).
module vec_mag_rr_arbiter #(
    parameter int COORD_WIDTH = 8,
    parameter int N_REQ       = 4,
    parameter int TAG_DEPTH   = 8,
    localparam int DW         = 4 * COORD_WIDTH,
    localparam int ID_W       = $clog2(N_REQ),
    localparam int CW         = $clog2(TAG_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ*DW-1:0] req_tdata,
    input  logic [N_REQ-1:0]    req_tvalid,
    input  logic [N_REQ-1:0]    req_tlast,
    output logic [N_REQ-1:0]    req_tready,
    output logic [DW-1:0]       core_s_tdata,
    output logic                core_s_tvalid,
    output logic                core_s_tlast,
    input  logic                core_s_tready,
    input  logic [DW-1:0]       core_m_tdata,
    input  logic                core_m_tvalid,
    input  logic                core_m_tlast,
    output logic                core_m_tready,
    output logic [DW-1:0]       rsp_tdata,
    output logic                rsp_tvalid,
    output logic                rsp_tlast,
    output logic [ID_W-1:0]     rsp_tdest,
    input  logic                rsp_tready,
    output logic [CW-1:0]       inflight_o,
    output logic                orphan_err_o
);

    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] search_id;
    logic            search_hit;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;

    logic [ID_W-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            orphan;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(TAG_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        search_hit = 1'b0;
        search_id  = rr_ptr;
        idx        = 0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = ID_W'(idx);
            if (req_tvalid[cand]) begin
                search_hit = 1'b1;
                search_id  = cand;
            end
        end
    end

`ifdef VEC_ARB_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;
    lock_state_t     state;
    logic [ID_W-1:0] lock_id;

    assign gnt_id    = (state == LOCKED) ? lock_id : search_id;
    assign gnt_valid = (state == LOCKED) ? req_tvalid[lock_id] : search_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else if (push) begin
            if (core_s_tlast) begin
                state  <= IDLE;
                rr_ptr <= next_id(gnt_id);
            end else begin
                state   <= LOCKED;
                lock_id <= gnt_id;
            end
        end
    end
`else
    assign gnt_id    = search_id;
    assign gnt_valid = search_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= next_id(gnt_id);
        end
    end
`endif

    assign fifo_full  = (count == CW'(TAG_DEPTH));
    assign fifo_empty = (count == '0);

    // Valid/ready outputs are gated by rst_n so they drop as soon as reset asserts.
    assign core_s_tvalid = rst_n & gnt_valid & ~fifo_full;
    assign core_s_tdata  = req_tdata[int'(gnt_id)*DW +: DW];
    assign core_s_tlast  = req_tlast[gnt_id];
    assign push          = core_s_tvalid & core_s_tready;

    always_comb begin
        req_tready         = '0;
        req_tready[gnt_id] = push;
    end

    assign rsp_tvalid    = rst_n & core_m_tvalid & ~fifo_empty;
    assign rsp_tdest     = tag_mem[rd_ptr];
    assign rsp_tdata     = core_m_tdata;
    assign rsp_tlast     = core_m_tlast;
    assign core_m_tready = rst_n & (fifo_empty | rsp_tready);
    assign pop           = rsp_tvalid & rsp_tready;
    assign orphan        = rst_n & core_m_tvalid & fifo_empty;

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            orphan_err_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (orphan) orphan_err_o <= 1'b1;
        end
    end

    assign inflight_o = count;

endmodule

// File: tb/tb_vec_mag_rr_arbiter.sv
// Directed bench for vec_mag_rr_arbiter; the bench itself plays both requesters and core.
// Packet-lock scenario runs only when VEC_ARB_PKT_LOCK_EN is defined.
module tb_vec_mag_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;

    logic            clk;
    logic            rst_n;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid;
    logic [N-1:0]    req_tlast;
    logic [N-1:0]    req_tready;
    logic [DW-1:0]   core_s_tdata;
    logic            core_s_tvalid;
    logic            core_s_tlast;
    logic            core_s_tready;
    logic [DW-1:0]   core_m_tdata;
    logic            core_m_tvalid;
    logic            core_m_tlast;
    logic            core_m_tready;
    logic [DW-1:0]   rsp_tdata;
    logic            rsp_tvalid;
    logic            rsp_tlast;
    logic [1:0]      rsp_tdest;
    logic            rsp_tready;
    logic [3:0]      inflight_o;
    logic            orphan_err_o;

    int checks;
    int failures;

    vec_mag_rr_arbiter #(
        .COORD_WIDTH(8),
        .N_REQ      (4),
        .TAG_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_tdata    (req_tdata),
        .req_tvalid   (req_tvalid),
        .req_tlast    (req_tlast),
        .req_tready   (req_tready),
        .core_s_tdata (core_s_tdata),
        .core_s_tvalid(core_s_tvalid),
        .core_s_tlast (core_s_tlast),
        .core_s_tready(core_s_tready),
        .core_m_tdata (core_m_tdata),
        .core_m_tvalid(core_m_tvalid),
        .core_m_tlast (core_m_tlast),
        .core_m_tready(core_m_tready),
        .rsp_tdata    (rsp_tdata),
        .rsp_tvalid   (rsp_tvalid),
        .rsp_tlast    (rsp_tlast),
        .rsp_tdest    (rsp_tdest),
        .rsp_tready   (rsp_tready),
        .inflight_o   (inflight_o),
        .orphan_err_o (orphan_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        core_s_tready = 1'b1;
        rsp_tready    = 1'b1;
        req_tvalid    = 4'hF;
        core_m_tvalid = 1'b1;
        #2;
        checks++; if (req_tready !== 4'h0) begin failures++; $display("[TB] FAIL reset_req_tready got %b want 0000", req_tready); end
        checks++; if (core_s_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_core_s_tvalid got %b want 0", core_s_tvalid); end
        checks++; if (core_m_tready !== 1'b0) begin failures++; $display("[TB] FAIL reset_core_m_tready got %b want 0", core_m_tready); end
        checks++; if (rsp_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_tvalid got %b want 0", rsp_tvalid); end
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_inflight got %0d want 0", inflight_o); end
        checks++; if (orphan_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_orphan got %b want 0", orphan_err_o); end
        core_s_tready = 1'b0;
        rsp_tready    = 1'b0;
        req_tvalid    = 4'h0;
        core_m_tvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // rr_ptr is 0 on entry; requester 2 alone is granted, result returns tagged 2.
    task automatic test_single_beat;
        req_tdata[2*DW +: DW] = 32'h0000_0403;
        req_tvalid    = 4'b0100;
        core_s_tready = 1'b1;
        #2;
        checks++; if (core_s_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL single_core_s_tvalid got %b want 1", core_s_tvalid); end
        checks++; if (core_s_tdata !== 32'h0000_0403) begin failures++; $display("[TB] FAIL single_core_s_tdata got %h want 00000403", core_s_tdata); end
        checks++; if (req_tready !== 4'b0100) begin failures++; $display("[TB] FAIL single_req_tready got %b want 0100", req_tready); end
        tick();
        req_tvalid = 4'h0;
        checks++; if (inflight_o !== 4'd1) begin failures++; $display("[TB] FAIL single_inflight_after_push got %0d want 1", inflight_o); end
        core_m_tvalid = 1'b1;
        core_m_tdata  = 32'd4;
        core_m_tlast  = 1'b1;
        rsp_tready    = 1'b1;
        #2;
        checks++; if (rsp_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL single_rsp_tvalid got %b want 1", rsp_tvalid); end
        checks++; if (rsp_tdest !== 2'd2) begin failures++; $display("[TB] FAIL single_rsp_tdest got %0d want 2", rsp_tdest); end
        checks++; if (rsp_tdata !== 32'd4) begin failures++; $display("[TB] FAIL single_rsp_tdata got %h want 4", rsp_tdata); end
        checks++; if (rsp_tlast !== 1'b1) begin failures++; $display("[TB] FAIL single_rsp_tlast got %b want 1", rsp_tlast); end
        tick();
        core_m_tvalid = 1'b0;
        core_m_tlast  = 1'b0;
        rsp_tready    = 1'b0;
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL single_inflight_after_pop got %0d want 0", inflight_o); end
        checks++; if (rsp_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL single_rsp_tvalid_idle got %b want 0", rsp_tvalid); end
    endtask

    // rr_ptr is 3 after requester 2 was served, so grants run 3,0,1,2,3,0,1,2.
    task automatic test_round_robin;
        int exp_id;
        for (int i = 0; i < N; i++) req_tdata[i*DW +: DW] = 32'hA0 + i;
        req_tvalid    = 4'hF;
        core_s_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_id = (3 + k) % N;
            #2;
            checks++; if (req_tready !== 4'(1 << exp_id)) begin failures++; $display("[TB] FAIL rr_grant_%0d got %b want id %0d", k, req_tready, exp_id); end
            checks++; if (core_s_tdata !== 32'hA0 + exp_id) begin failures++; $display("[TB] FAIL rr_tdata_%0d got %h want %h", k, core_s_tdata, 32'hA0 + exp_id); end
            tick();
        end
        req_tvalid = 4'h0;
        checks++; if (inflight_o !== 4'd8) begin failures++; $display("[TB] FAIL rr_inflight_full got %0d want 8", inflight_o); end
        core_m_tvalid = 1'b1;
        rsp_tready    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_id = (3 + k) % N;
            #2;
            checks++; if (rsp_tdest !== 2'(exp_id)) begin failures++; $display("[TB] FAIL rr_tdest_%0d got %0d want %0d", k, rsp_tdest, exp_id); end
            tick();
        end
        core_m_tvalid = 1'b0;
        rsp_tready    = 1'b0;
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL rr_inflight_drained got %0d want 0", inflight_o); end
    endtask

    // Requesters 0 and 2 offer 5 beats each; rr_ptr starts at 3 so grants alternate 0,2,...
    task automatic test_backpressure_full;
        int rem0;
        int rem2;
        int acc;
        int exp_id;
        rem0 = 5;
        rem2 = 5;
        acc  = 0;
        core_s_tready = 1'b1;
        rsp_tready    = 1'b0;
        core_m_tvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_tvalid = {1'b0, rem2 > 0, 1'b0, rem0 > 0};
            #2;
            if (req_tready !== 4'h0) begin
                exp_id = (acc % 2 == 0) ? 0 : 2;
                checks++; if (req_tready !== 4'(1 << exp_id)) begin failures++; $display("[TB] FAIL bp_grant_%0d got %b want id %0d", acc, req_tready, exp_id); end
                if (req_tready[0]) rem0--;
                if (req_tready[2]) rem2--;
                acc++;
            end
            tick();
        end
        checks++; if (acc !== 8) begin failures++; $display("[TB] FAIL bp_accepted_while_stalled got %0d want 8", acc); end
        checks++; if (inflight_o !== 4'd8) begin failures++; $display("[TB] FAIL bp_inflight got %0d want 8", inflight_o); end
        #2;
        checks++; if (req_tready !== 4'h0) begin failures++; $display("[TB] FAIL bp_req_tready_full got %b want 0000", req_tready); end
        checks++; if (core_s_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL bp_core_s_tvalid_full got %b want 0", core_s_tvalid); end
        tick();
        rsp_tready    = 1'b1;
        core_m_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_tvalid = {1'b0, rem2 > 0, 1'b0, rem0 > 0};
            #2;
            checks++; if (rsp_tvalid !== 1'b1 || rsp_tdest !== ((k % 2 == 0) ? 2'd0 : 2'd2)) begin
                failures++; $display("[TB] FAIL bp_pop_%0d got valid %b dest %0d want valid 1 dest %0d", k, rsp_tvalid, rsp_tdest, (k % 2 == 0) ? 0 : 2);
            end
            if (req_tready !== 4'h0) begin
                exp_id = (acc % 2 == 0) ? 0 : 2;
                checks++; if (req_tready !== 4'(1 << exp_id)) begin failures++; $display("[TB] FAIL bp_grant_%0d got %b want id %0d", acc, req_tready, exp_id); end
                if (req_tready[0]) rem0--;
                if (req_tready[2]) rem2--;
                acc++;
            end
            tick();
        end
        req_tvalid    = 4'h0;
        core_m_tvalid = 1'b0;
        rsp_tready    = 1'b0;
        checks++; if (acc !== 10) begin failures++; $display("[TB] FAIL bp_accepted_total got %0d want 10", acc); end
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL bp_inflight_drained got %0d want 0", inflight_o); end
    endtask

    task automatic test_orphan;
        core_m_tvalid = 1'b1;
        core_m_tdata  = 32'h0000_DEAD;
        rsp_tready    = 1'b0;
        #2;
        checks++; if (rsp_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL orphan_rsp_tvalid got %b want 0", rsp_tvalid); end
        checks++; if (core_m_tready !== 1'b1) begin failures++; $display("[TB] FAIL orphan_core_m_tready got %b want 1", core_m_tready); end
        checks++; if (orphan_err_o !== 1'b0) begin failures++; $display("[TB] FAIL orphan_before_edge got %b want 0", orphan_err_o); end
        tick();
        core_m_tvalid = 1'b0;
        checks++; if (orphan_err_o !== 1'b1) begin failures++; $display("[TB] FAIL orphan_set got %b want 1", orphan_err_o); end
        tick();
        checks++; if (orphan_err_o !== 1'b1) begin failures++; $display("[TB] FAIL orphan_sticky got %b want 1", orphan_err_o); end
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL orphan_inflight got %0d want 0", inflight_o); end
    endtask

    // rr_ptr is 3 here; requester 1 pushes 3 beats, then reset hits mid-cycle.
    task automatic test_reset_inflight;
        req_tvalid    = 4'b0010;
        core_s_tready = 1'b1;
        rsp_tready    = 1'b0;
        tick();
        tick();
        tick();
        req_tvalid = 4'h0;
        checks++; if (inflight_o !== 4'd3) begin failures++; $display("[TB] FAIL rstf_inflight_before got %0d want 3", inflight_o); end
        rst_n         = 1'b0;
        core_m_tvalid = 1'b1;
        rsp_tready    = 1'b1;
        req_tvalid    = 4'hF;
        #1;
        checks++; if (inflight_o !== 4'd0) begin failures++; $display("[TB] FAIL rstf_inflight got %0d want 0", inflight_o); end
        checks++; if (orphan_err_o !== 1'b0) begin failures++; $display("[TB] FAIL rstf_orphan got %b want 0", orphan_err_o); end
        checks++; if (req_tready !== 4'h0) begin failures++; $display("[TB] FAIL rstf_req_tready got %b want 0000", req_tready); end
        checks++; if (core_s_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL rstf_core_s_tvalid got %b want 0", core_s_tvalid); end
        checks++; if (rsp_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL rstf_rsp_tvalid got %b want 0", rsp_tvalid); end
        checks++; if (core_m_tready !== 1'b0) begin failures++; $display("[TB] FAIL rstf_core_m_tready got %b want 0", core_m_tready); end
        req_tvalid    = 4'h0;
        core_m_tvalid = 1'b0;
        rsp_tready    = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        req_tvalid = 4'hF;
        #1;
        checks++; if (req_tready !== 4'b0001) begin failures++; $display("[TB] FAIL rstf_rr_ptr_zero got %b want 0001", req_tready); end
        req_tvalid = 4'h0;
        tick();
    endtask

`ifdef VEC_ARB_PKT_LOCK_EN
    // rr_ptr is 0; req1 must wait through all three beats of req0's packet.
    task automatic test_pkt_lock;
        core_s_tready = 1'b1;
        req_tvalid    = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            req_tlast = {3'b000, c == 2};
            #2;
            checks++; if (req_tready !== 4'b0001) begin failures++; $display("[TB] FAIL lock_beat_%0d got %b want 0001", c, req_tready); end
            tick();
        end
        req_tvalid = 4'b0010;
        req_tlast  = 4'h0;
        #2;
        checks++; if (req_tready !== 4'b0010) begin failures++; $display("[TB] FAIL lock_release got %b want 0010", req_tready); end
        tick();
        req_tvalid    = 4'h0;
        core_s_tready = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b1;
        req_tdata     = '0;
        req_tvalid    = '0;
        req_tlast     = '0;
        core_s_tready = 1'b0;
        core_m_tdata  = '0;
        core_m_tvalid = 1'b0;
        core_m_tlast  = 1'b0;
        rsp_tready    = 1'b0;
        #1;
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure_full();
        test_orphan();
        test_reset_inflight();
`ifdef VEC_ARB_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
